// File: rtl/digit_scan_controller.sv
// Multiplexed-display digit scanner: steps a 2-bit digit select through the enabled digits.
// Optional blanking interval between digits is compiled in with DIGIT_SCAN_CONTROLLER_BLANK_EN.
module digit_scan_controller #(
  parameter int PRESCALE    = 1000,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       run,
  input  logic [3:0] mask,
  output logic       sel1,
  output logic       sel0,
  output logic       en,
  output logic       frame
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [7:0]  DWELL_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK_TICKS - 1);

  state_t      state, state_n;
  logic [15:0] pre, pre_n;
  logic [7:0]  tcnt, tcnt_n;
  logic [1:0]  sel, sel_n;
  logic [3:0]  mask_q, mask_n;
  logic        en_n, frame_n;
  logic        tick, dwell_done, blank_done;

  // Next set bit strictly above cur, wrapping; cur itself is found last (i = 4).
  function automatic logic [1:0] next_digit(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] idx;
    next_digit = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) next_digit = idx;
    end
  endfunction

  function automatic logic [1:0] highest_digit(input logic [3:0] m);
    highest_digit = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) highest_digit = 2'(i);
    end
  endfunction

  assign tick       = (pre == PRE_LAST);
  assign dwell_done = tick && (tcnt == DWELL_LAST);
  assign blank_done = tick && (tcnt == BLANK_LAST);

  always_comb begin
    state_n = state;
    pre_n   = pre;
    tcnt_n  = tcnt;
    sel_n   = sel;
    mask_n  = mask_q;
    en_n    = 1'b0;
    frame_n = 1'b0;

    case (state)
      IDLE: begin
        pre_n  = '0;
        tcnt_n = '0;
        if (run && (mask != 4'd0)) begin
          state_n = SHOW;
          sel_n   = next_digit(mask, 2'd3);
          mask_n  = mask;
          en_n    = 1'b1;
        end
      end

      SHOW: begin
        en_n  = 1'b1;
        pre_n = tick ? 16'd0 : pre + 16'd1;
        if (tick) tcnt_n = tcnt + 8'd1;
        if (dwell_done) begin
          tcnt_n  = '0;
          // Frame tracks the mask captured at the last digit decision, not the live input.
          frame_n = (sel == highest_digit(mask_q));
`ifdef DIGIT_SCAN_CONTROLLER_BLANK_EN
          state_n = BLANK;
          en_n    = 1'b0;
`else
          if (mask == 4'd0) begin
            state_n = IDLE;
            en_n    = 1'b0;
          end else begin
            sel_n  = next_digit(mask, sel);
            mask_n = mask;
          end
`endif
        end
      end

      BLANK: begin
        pre_n = tick ? 16'd0 : pre + 16'd1;
        if (tick) tcnt_n = tcnt + 8'd1;
        if (blank_done) begin
          tcnt_n = '0;
          if (mask == 4'd0) begin
            state_n = IDLE;
          end else begin
            state_n = SHOW;
            sel_n   = next_digit(mask, sel);
            mask_n  = mask;
            en_n    = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Dropping run wins over any simultaneous tick expiry.
    if (!run) begin
      state_n = IDLE;
      pre_n   = '0;
      tcnt_n  = '0;
      sel_n   = sel;
      mask_n  = mask_q;
      en_n    = 1'b0;
      frame_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      pre    <= '0;
      tcnt   <= '0;
      sel    <= '0;
      mask_q <= '0;
      en     <= 1'b0;
      frame  <= 1'b0;
    end else begin
      state  <= state_n;
      pre    <= pre_n;
      tcnt   <= tcnt_n;
      sel    <= sel_n;
      mask_q <= mask_n;
      en     <= en_n;
      frame  <= frame_n;
    end
  end

  assign sel1 = sel[1];
  assign sel0 = sel[0];

endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller at PRESCALE=2, DWELL_TICKS=2, BLANK_TICKS=1.
// Expected timing follows DIGIT_SCAN_CONTROLLER_BLANK_EN: 4 show cycles plus 2 blank cycles when defined.
module tb_digit_scan_controller;

`ifdef DIGIT_SCAN_CONTROLLER_BLANK_EN
  localparam int T = 6;
`else
  localparam int T = 4;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       run = 1'b0;
  logic [3:0] mask = 4'd0;
  logic       sel1, sel0, en, frame;

  int n_cmp = 0;
  int n_bad = 0;

  digit_scan_controller #(
    .PRESCALE(2),
    .DWELL_TICKS(2),
    .BLANK_TICKS(1)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .run(run),
    .mask(mask),
    .sel1(sel1),
    .sel0(sel0),
    .en(en),
    .frame(frame)
  );

  always #5 clk = ~clk;

  // Observed/expected vectors are {sel1, sel0, en, frame}.
  task automatic go_idle();
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rstN = 1'b0;
    run  = 1'b1;
    mask = 4'hf;
    repeat (2) @(negedge clk);
    exp = 4'b0000;
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL reset_hold obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
    run  = 1'b0;
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL idle_run0 obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] exp;
    int d, p;
    mask = 4'hf;
    run  = 1'b1;
    for (int k = 1; k <= 8 * T + 2; k++) begin
      @(negedge clk);
      d = (k - 1) / T;
      p = (k - 1) % T;
      exp = {2'(d % 4), (p < 4),
             (k >= 5) && ((k - 5) % T == 0) && (((k - 5) / T) % 4 == 3)};
      n_cmp++;
      if ({sel1, sel0, en, frame} !== exp) begin
        n_bad++;
        $display("FAIL full_scan k=%0d obs=%b exp=%b", k, {sel1, sel0, en, frame}, exp);
      end
    end
    go_idle();
  endtask

  task automatic test_sparse_mask();
    logic [3:0] exp;
    int d, p;
    mask = 4'b1010;
    run  = 1'b1;
    for (int k = 1; k <= 4 * T + 2; k++) begin
      @(negedge clk);
      d = (k - 1) / T;
      p = (k - 1) % T;
      exp = {((d % 2) == 1) ? 2'd3 : 2'd1, (p < 4),
             (k >= 5) && ((k - 5) % T == 0) && (((k - 5) / T) % 2 == 1)};
      n_cmp++;
      if ({sel1, sel0, en, frame} !== exp) begin
        n_bad++;
        $display("FAIL sparse_mask k=%0d obs=%b exp=%b", k, {sel1, sel0, en, frame}, exp);
      end
    end
    go_idle();
  endtask

  task automatic test_mask_change();
    logic [3:0] exp;
    int d, p;
    mask = 4'hf;
    run  = 1'b1;
    for (int k = 1; k <= 5 * T + 2; k++) begin
      @(negedge clk);
      d = (k - 1) / T;
      p = (k - 1) % T;
      exp = {(d < 2) ? 2'(d) : 2'd0, (p < 4),
             (k >= 5) && ((k - 5) % T == 0) && (((k - 5) / T) >= 2)};
      n_cmp++;
      if ({sel1, sel0, en, frame} !== exp) begin
        n_bad++;
        $display("FAIL mask_change k=%0d obs=%b exp=%b", k, {sel1, sel0, en, frame}, exp);
      end
      if (k == T + 2) mask = 4'b0001;
    end
    go_idle();
  endtask

  task automatic test_run_drop();
    logic [3:0] exp;
    mask = 4'hf;
    run  = 1'b1;
    // Digit 3 finishes its dwell on the cycle run is seen low.
    repeat (3 * T + 4) @(negedge clk);
    exp = 4'b1110;
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL run_drop_pre obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
    run = 1'b0;
    exp = 4'b1100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({sel1, sel0, en, frame} !== exp) begin
        n_bad++;
        $display("FAIL run_drop k=%0d obs=%b exp=%b", k, {sel1, sel0, en, frame}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp;
    mask = 4'hf;
    run  = 1'b1;
    repeat (T + 2) @(negedge clk);
    exp = 4'b0110;
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL async_pre obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
    #1 rstN = 1'b0;
    #1;
    exp = 4'b0000;
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL async_reset obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
    @(negedge clk);
    rstN = 1'b1;
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL reset_release obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
    @(negedge clk);
    exp = 4'b0010;
    n_cmp++;
    if ({sel1, sel0, en, frame} !== exp) begin
      n_bad++;
      $display("FAIL first_after_reset obs=%b exp=%b", {sel1, sel0, en, frame}, exp);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_mask_change();
    test_run_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
